// File: rtl/gpr_pkg.sv
// Shared definitions for the multi-port GPR file.
//   gpr_state_t : clear-sequencer state encoding (ST_IDLE, ST_CLEAR)
//   gpr_depth() : register count derived from the address width
//   REG_ZERO    : index of the hard-wired zero register
package gpr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } gpr_state_t;

    localparam int REG_ZERO = 0;

    function automatic int gpr_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/gpr_clear_fsm.sv
// Bulk-clear sequencer for the GPR file. Walks a pointer over every register,
// one per clock, and tells the array to zero it.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset; forces (re)start of a clear
//   clr_req  in   start a clear; only looked at while idle
//   clr_busy out  high while the sweep is running
//   clr_we   out  zero-write strobe for the array / scoreboard
//   clr_addr out  register being cleared this cycle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal operation, waiting for clr_req
// ST_CLEAR | zeroing mem[ptr] and busy[ptr] each cycle, ptr 0..DEPTH-1
module gpr_clear_fsm #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    import gpr_pkg::*;

    localparam int DEPTH = gpr_depth(ADDR_W);
    // Stopping on the last index keeps the pointer at ADDR_W bits without wrap.
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    gpr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file with busy scoreboard and a
// sequenced bulk clear. Register 0 is hard-wired to zero.
// Optional feature macro: GPR_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_addr / rd_data   NUM_RD packed combinational read ports
//   rd_busy             busy bit of each read port's register
//   wr0_* / wr1_*       write ports; wr1 wins on an address collision
//   set_busy, busy_addr mark a register busy at instruction issue
//   clr_req             start a bulk clear (idle only)
//   clr_busy            clear sweep in progress; reads forced to zero
module gpr_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        busy_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);
    import gpr_pkg::*;

    localparam int DEPTH = gpr_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    gpr_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write ports are only honoured outside the clear sweep.
    logic wr0_ok, wr1_ok;
    assign wr0_ok = wr0_en && !clr_we && (wr0_addr != ADDR_ZERO);
    assign wr1_ok = wr1_en && !clr_we && (wr1_addr != ADDR_ZERO);

    // Array has no reset; its contents are zeroed by the clear sweep.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0_ok) mem[wr0_addr] <= wr0_data;
            // Later assignment wins, giving wr1 priority on a collision.
            if (wr1_ok) mem[wr1_addr] <= wr1_data;
        end
    end

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_we) begin
            busy_d[clr_addr] = 1'b0;
        end else begin
            if (wr0_ok) busy_d[wr0_addr] = 1'b0;
            if (wr1_ok) busy_d[wr1_addr] = 1'b0;
            // Applied after the clears so a same-cycle issue keeps the bit set.
            if (set_busy) busy_d[busy_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
            bsy  = busy_q[addr];
`ifdef GPR_BYPASS_EN
            if (wr1_ok && (wr1_addr == addr)) begin
                data = wr1_data;
                bsy  = 1'b0;
            end else if (wr0_ok && (wr0_addr == addr)) begin
                data = wr0_data;
                bsy  = 1'b0;
            end
`endif
            if (clr_busy || (addr == ADDR_ZERO)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_busy[i]                  = bsy;
    end

endmodule
